bconvex_scheduler: RTL

Shares one `fastBConvEx_BBa_to_q` conversion unit between `NUM_REQ` requesters, such as the c0/c1 ciphertext-component paths of the modulus-switch stage. The block:

- arbitrates round-robin and latches the winner's BBa polynomial;
- issues a one-cycle start pulse and holds the operand stable for the whole conversion;
- captures the q-basis result and returns it to the owner over a valid/ready handshake.

Only one job is in flight at a time, because the conversion unit's internal registers are not gated per job.

---
 rtl/bconvex_sched_pkg.sv | 26 ++
 rtl/bconvex_scheduler_rr_arbiter.sv | 33 +++
 rtl/bconvex_scheduler.sv | 128 ++++++++++++
 3 files changed

// File: rtl/bconvex_sched_pkg.sv
// Shared types for the BConvEx scheduler: ring geometry, residue/polynomial
// types, FSM state encoding and the owner-index width helper.
package bconvex_sched_pkg;

    localparam int N_SLOTS       = 4;
    localparam int BBa_BASIS_LEN = 2;
    localparam int q_BASIS_LEN   = 3;
    localparam int RESIDUE_W     = 16;

    typedef logic [RESIDUE_W-1:0] rns_residue_t;
    typedef rns_residue_t [N_SLOTS-1:0][BBa_BASIS_LEN-1:0] bba_poly_t;
    typedef rns_residue_t [N_SLOTS-1:0][q_BASIS_LEN-1:0]   q_poly_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } sched_state_t;

    // A single requester still needs a one-bit owner field.
    function automatic int owner_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bconvex_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above rr_ptr,
// wrapping around to index 0.
module rr_arbiter
    import bconvex_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = owner_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    int  cand;
    logic found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(rr_ptr) + i) % NUM_REQ;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/bconvex_scheduler.sv
// Shares one BBa->q basis conversion unit between NUM_REQ requesters, one job
// in flight at a time, with a round-robin grant and a WAIT-phase timeout.
module bconvex_scheduler
    import bconvex_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  bba_poly_t [NUM_REQ-1:0] req_poly,
    output logic                 conv_in_valid,
    output bba_poly_t            conv_input_RNSpoly,
    input  logic                 conv_out_valid,
    input  q_poly_t              conv_output_RNSpoly,
    output logic [NUM_REQ-1:0]   resp_valid,
    input  logic [NUM_REQ-1:0]   resp_ready,
    output q_poly_t              resp_poly,
    output logic                 busy,
    output logic                 err
);

    localparam int IDX_W = owner_width(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    sched_state_t       state, state_next;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;
    logic [CNT_W-1:0]   wait_cnt;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               grant_fire;
    logic               capture;
    logic               timeout_hit;
    logic               stray_result;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .grant  (arb_grant),
        .idx    (arb_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        req_ready     = '0;
        conv_in_valid = 1'b0;
        resp_valid    = '0;
        grant_fire    = 1'b0;
        capture       = 1'b0;
        timeout_hit   = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = arb_grant;
                if (|req_valid) begin
                    grant_fire = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                conv_in_valid = 1'b1;
                state_next    = S_WAIT;
            end
            S_WAIT: begin
                // A result in the final counted cycle still wins over the timeout.
                if (conv_out_valid) begin
                    capture    = 1'b1;
                    state_next = S_RESP;
                end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_next  = S_IDLE;
                end
            end
            S_RESP: begin
                resp_valid[owner] = 1'b1;
                if (resp_ready[owner]) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign stray_result = conv_out_valid && (state != S_WAIT);
    assign busy         = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr             <= '0;
            owner              <= '0;
            wait_cnt           <= '0;
            conv_input_RNSpoly <= '0;
            resp_poly          <= '0;
            err                <= 1'b0;
        end else begin
            if (grant_fire) begin
                conv_input_RNSpoly <= req_poly[arb_idx];
                owner              <= arb_idx;
                rr_ptr             <= (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + 1'b1;
            end
            if (state == S_ISSUE) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (capture) begin
                resp_poly <= conv_output_RNSpoly;
            end
            if (timeout_hit || stray_result) begin
                err <= 1'b1;
            end
        end
    end

endmodule
